// File: rtl/periph_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared peripheral bus.
// A watchdog forces completion with a fixed error word if the slave never answers.
module periph_bus_arbiter #(
    parameter int          ADDR_W         = 31,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic              sys_clk,
    input  logic              rst_n,

    input  logic              i_m0_valid,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic              i_m0_write,
    input  logic [31:0]       i_m0_wdata,
    input  logic [3:0]        i_m0_wstrb,
    output logic [31:0]       o_m0_rdata,
    output logic              o_m0_ready,

    input  logic              i_m1_valid,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic              i_m1_write,
    input  logic [31:0]       i_m1_wdata,
    input  logic [3:0]        i_m1_wstrb,
    output logic [31:0]       o_m1_rdata,
    output logic              o_m1_ready,

    output logic              o_s_valid,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic              o_s_write,
    output logic [31:0]       o_s_wdata,
    output logic [3:0]        o_s_wstrb,
    input  logic [31:0]       i_s_rdata,
    input  logic              i_s_ready,

    output logic              o_timeout_err,
    output logic              o_timeout_master
);

    localparam int          TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t        r_state;
    logic          r_grant;
    logic          r_last_grant;
    logic [TW-1:0] r_timer;
    logic          r_timeout_master;

    logic          w_busy;
    logic          w_timeout;
    logic          w_complete;
    logic          w_next_grant;
    logic [31:0]   w_rdata;

    assign w_busy     = (r_state == ST_BUSY);
    assign w_timeout  = w_busy && !i_s_ready && (r_timer == TLAST);
    assign w_complete = (w_busy && i_s_ready) || w_timeout;
    assign w_rdata    = i_s_ready ? i_s_rdata : TIMEOUT_RDATA;

    // On contention the master that did not win last time is chosen.
    assign w_next_grant = (i_m0_valid && i_m1_valid) ? ~r_last_grant : i_m1_valid;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_grant          <= 1'b0;
            r_last_grant     <= 1'b1;
            r_timer          <= '0;
            r_timeout_master <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_m0_valid || i_m1_valid) begin
                        r_grant <= w_next_grant;
                        r_timer <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_complete) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant;
                        if (w_timeout) begin
                            r_timeout_master <= r_grant;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_s_valid = w_busy;
    assign o_s_addr  = !w_busy ? '0 : (r_grant ? i_m1_addr  : i_m0_addr);
    assign o_s_write = w_busy && (r_grant ? i_m1_write : i_m0_write);
    assign o_s_wdata = !w_busy ? '0 : (r_grant ? i_m1_wdata : i_m0_wdata);
    assign o_s_wstrb = !w_busy ? '0 : (r_grant ? i_m1_wstrb : i_m0_wstrb);

    // Completion is steered only to the granted master; the other sees zeros.
    assign o_m0_ready = w_complete && !r_grant;
    assign o_m1_ready = w_complete &&  r_grant;
    assign o_m0_rdata = o_m0_ready ? w_rdata : 32'h0;
    assign o_m1_rdata = o_m1_ready ? w_rdata : 32'h0;

    assign o_timeout_err    = w_timeout;
    assign o_timeout_master = w_timeout ? r_grant : r_timeout_master;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed self-checking bench for periph_bus_arbiter with an 8-cycle watchdog.
module tb_periph_bus_arbiter;

    logic        sysClk = 1'b0;
    logic        rstN;
    logic        m0Valid, m0Write, m1Valid, m1Write;
    logic [30:0] m0Addr, m1Addr;
    logic [31:0] m0Wdata, m1Wdata;
    logic [3:0]  m0Wstrb, m1Wstrb;
    logic [31:0] m0Rdata, m1Rdata;
    logic        m0Ready, m1Ready;
    logic        sValid, sWrite;
    logic [30:0] sAddr;
    logic [31:0] sWdata, sRdata;
    logic [3:0]  sWstrb;
    logic        sReady;
    logic        timeoutErr, timeoutMaster;

    int checkCount = 0;
    int errorCount = 0;

    periph_bus_arbiter #(
        .ADDR_W(31), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)
    ) dut (
        .sys_clk(sysClk), .rst_n(rstN),
        .i_m0_valid(m0Valid), .i_m0_addr(m0Addr), .i_m0_write(m0Write),
        .i_m0_wdata(m0Wdata), .i_m0_wstrb(m0Wstrb),
        .o_m0_rdata(m0Rdata), .o_m0_ready(m0Ready),
        .i_m1_valid(m1Valid), .i_m1_addr(m1Addr), .i_m1_write(m1Write),
        .i_m1_wdata(m1Wdata), .i_m1_wstrb(m1Wstrb),
        .o_m1_rdata(m1Rdata), .o_m1_ready(m1Ready),
        .o_s_valid(sValid), .o_s_addr(sAddr), .o_s_write(sWrite),
        .o_s_wdata(sWdata), .o_s_wstrb(sWstrb),
        .i_s_rdata(sRdata), .i_s_ready(sReady),
        .o_timeout_err(timeoutErr), .o_timeout_master(timeoutMaster)
    );

    always #5 sysClk = ~sysClk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int master, input logic valid, input logic [30:0] addr,
                                 input logic write, input logic [31:0] wdata, input logic [3:0] wstrb);
        if (master == 0) begin
            m0Valid = valid; m0Addr = addr; m0Write = write; m0Wdata = wdata; m0Wstrb = wstrb;
        end else begin
            m1Valid = valid; m1Addr = addr; m1Write = write; m1Wdata = wdata; m1Wstrb = wstrb;
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(0, 0, 31'h0, 0, 32'h0, 4'h0);
        applyStimulus(1, 0, 31'h0, 0, 32'h0, 4'h0);
        sReady = 1'b0;
        sRdata = 32'h0;
        #12;
        checkOutput("rst_s_valid", sValid, 0);
        checkOutput("rst_s_addr", sAddr, 0);
        checkOutput("rst_s_wdata", sWdata, 0);
        checkOutput("rst_ready", {m0Ready, m1Ready}, 0);
        checkOutput("rst_rdata", {m0Rdata, m1Rdata}, 0);
        checkOutput("rst_timeout", {timeoutErr, timeoutMaster}, 0);
        tick();
        rstN = 1'b1;
        tick();

        // Single write from master 0, slave responds in the second BUSY cycle.
        applyStimulus(0, 1, 31'h4, 1, 32'h41, 4'b0001);
        #1 checkOutput("wr_svalid_idle", sValid, 0);
        tick();
        checkOutput("wr_svalid_busy", sValid, 1);
        checkOutput("wr_s_addr", sAddr, 31'h4);
        checkOutput("wr_s_write", sWrite, 1);
        checkOutput("wr_s_wdata", sWdata, 32'h41);
        checkOutput("wr_s_wstrb", sWstrb, 4'b0001);
        checkOutput("wr_m0_ready_early", m0Ready, 0);
        tick();
        sReady = 1'b1;
        #1 checkOutput("wr_m0_ready", m0Ready, 1);
        checkOutput("wr_m1_ready", m1Ready, 0);
        tick();
        sReady = 1'b0;
        applyStimulus(0, 0, 31'h0, 0, 32'h0, 4'h0);
        #1 checkOutput("wr_svalid_after", sValid, 0);
        checkOutput("wr_m0_ready_after", m0Ready, 0);

        // Read from master 1, slave answers in the fourth BUSY cycle.
        applyStimulus(1, 1, 31'h10, 0, 32'h0, 4'h0);
        tick();
        checkOutput("rd_s_addr", sAddr, 31'h10);
        checkOutput("rd_s_write", sWrite, 0);
        tick(); tick(); tick();
        sReady = 1'b1;
        sRdata = 32'h1234_5678;
        #1 checkOutput("rd_m1_ready", m1Ready, 1);
        checkOutput("rd_m1_rdata", m1Rdata, 32'h1234_5678);
        checkOutput("rd_m0_ready", m0Ready, 0);
        checkOutput("rd_m0_rdata", m0Rdata, 0);
        tick();
        sReady = 1'b0;
        sRdata = 32'h0;
        applyStimulus(1, 0, 31'h0, 0, 32'h0, 4'h0);

        // Contention from reset: grants must alternate starting with master 0.
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        applyStimulus(0, 1, 31'h100, 1, 32'hA0A0_A0A0, 4'hF);
        applyStimulus(1, 1, 31'h200, 1, 32'hB1B1_B1B1, 4'h3);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("cont%0d_s_addr", i), sAddr, (i % 2 == 0) ? 31'h100 : 31'h200);
            checkOutput($sformatf("cont%0d_s_wdata", i), sWdata, (i % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1);
            checkOutput($sformatf("cont%0d_s_wstrb", i), sWstrb, (i % 2 == 0) ? 4'hF : 4'h3);
            sReady = 1'b1;
            #1 checkOutput($sformatf("cont%0d_ready", i), {m0Ready, m1Ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            sReady = 1'b0;
            #1 checkOutput($sformatf("cont%0d_gap", i), sValid, 0);
        end
        applyStimulus(0, 0, 31'h0, 0, 32'h0, 4'h0);
        applyStimulus(1, 0, 31'h0, 0, 32'h0, 4'h0);
        tick();

        // Timeout on master 0 with master 1 pending, then a timeout on master 1.
        applyStimulus(0, 1, 31'h300, 0, 32'h0, 4'h0);
        applyStimulus(1, 1, 31'h304, 0, 32'h0, 4'h0);
        tick();
        checkOutput("to0_s_addr", sAddr, 31'h300);
        for (int k = 1; k < 8; k++) begin
            checkOutput($sformatf("to0_wait%0d", k), {m0Ready, timeoutErr}, 2'b00);
            tick();
        end
        checkOutput("to0_m0_ready", m0Ready, 1);
        checkOutput("to0_m0_rdata", m0Rdata, 32'hDEAD_BEEF);
        checkOutput("to0_err", timeoutErr, 1);
        checkOutput("to0_master", timeoutMaster, 0);
        tick();
        applyStimulus(0, 0, 31'h0, 0, 32'h0, 4'h0);
        #1 checkOutput("to0_err_pulse", timeoutErr, 0);
        checkOutput("to0_gap", sValid, 0);
        tick();
        checkOutput("to1_s_addr", sAddr, 31'h304);
        for (int k = 1; k < 8; k++) tick();
        checkOutput("to1_m1_ready", m1Ready, 1);
        checkOutput("to1_m1_rdata", m1Rdata, 32'hDEAD_BEEF);
        checkOutput("to1_err", timeoutErr, 1);
        checkOutput("to1_master", timeoutMaster, 1);
        tick();
        applyStimulus(1, 0, 31'h0, 0, 32'h0, 4'h0);
        #1 checkOutput("to1_master_hold", timeoutMaster, 1);
        checkOutput("to1_err_pulse", timeoutErr, 0);

        // s_ready on the last watchdog cycle wins over the timeout.
        applyStimulus(0, 1, 31'h400, 0, 32'h0, 4'h0);
        tick();
        for (int k = 1; k < 8; k++) tick();
        sReady = 1'b1;
        sRdata = 32'hCAFE_F00D;
        #1 checkOutput("tie_m0_ready", m0Ready, 1);
        checkOutput("tie_m0_rdata", m0Rdata, 32'hCAFE_F00D);
        checkOutput("tie_err", timeoutErr, 0);
        checkOutput("tie_master_hold", timeoutMaster, 1);
        tick();
        applyStimulus(0, 0, 31'h0, 0, 32'h0, 4'h0);
        #1 checkOutput("stray_ready0", {m0Ready, m1Ready}, 0);
        tick();
        checkOutput("stray_ready1", {m0Ready, m1Ready, sValid}, 0);
        sReady = 1'b0;
        sRdata = 32'h0;

        // Reset two cycles into a master 1 transaction; last winner was master 0.
        applyStimulus(1, 1, 31'h500, 0, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("mid_busy", sValid, 1);
        sReady = 1'b1;
        rstN = 1'b0;
        #1 checkOutput("mid_rst_svalid", sValid, 0);
        checkOutput("mid_rst_ready", {m0Ready, m1Ready}, 0);
        checkOutput("mid_rst_timeout", {timeoutErr, timeoutMaster}, 0);
        tick();
        sReady = 1'b0;
        applyStimulus(0, 1, 31'h600, 0, 32'h0, 4'h0);
        rstN = 1'b1;
        tick();
        checkOutput("post_rst_grant", sAddr, 31'h600);
        sReady = 1'b1;
        #1 checkOutput("post_rst_ready", {m0Ready, m1Ready}, 2'b10);
        tick();
        sReady = 1'b0;
        applyStimulus(0, 0, 31'h0, 0, 32'h0, 4'h0);
        applyStimulus(1, 0, 31'h0, 0, 32'h0, 4'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-requester arbiter sharing the single peripheral memory bus (valid/ready, 31-bit word address, wstrb) of the CPU subsystem.
- Requester 0 is the CPU periph port; requester 1 is a future DMA/debug master.
- Round-robin grant, one transaction at a time, locked until completion.
- Per-transaction watchdog: a silent slave completes the transaction with a fixed error word, so no requester hangs.

Parameters:
- ADDR_W, 31, address width of all ports.
- TIMEOUT_CYCLES, 256, BUSY cycles without s_ready before forced completion (≥2).
- TIMEOUT_RDATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_valid / m1_valid  in  1  request; held with payload stable until that master's ready
- m0_addr / m1_addr  in  ADDR_W  address
- m0_write / m1_write  in  1  1=write
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte strobes
- m0_rdata / m1_rdata  out  32  read data, valid while that master's ready=1
- m0_ready / m1_ready  out  1  single-cycle completion pulse
- s_valid  out  1  request to shared bus
- s_addr, s_write, s_wdata, s_wstrb  out  ADDR_W/1/32/4  payload of granted master
- s_rdata  in  32  slave read data
- s_ready  in  1  slave completion
- timeout_err  out  1  one-cycle pulse on forced completion
- timeout_master  out  1  master index of last timeout; holds until next timeout

Behaviour:
- Reset: state=IDLE, grant=0, last_grant=1 (master 0 wins first contest), timer=0.
  - All outputs 0: s_valid, s_addr, s_write, s_wdata, s_wstrb, m*_ready, m*_rdata, timeout_err, timeout_master.
- IDLE:
  - s_valid=0.
  - If exactly one m*_valid: grant it.
  - If both: grant the master != last_grant.
  - Registered: go to BUSY next cycle, timer=0.
  - Minimum arbitration latency is 1 cycle; s_valid first rises the cycle after the m_valid is sampled.
- BUSY:
  - s_valid=1; s_* payload driven combinationally from the granted master.
  - On s_ready=1:
    - m[grant]_ready=1 and m[grant]_rdata=s_rdata in the same cycle (combinational).
    - Next cycle: state=IDLE, last_grant=grant.
  - Else timer++.
  - When timer reaches TIMEOUT_CYCLES-1 with s_ready=0:
    - m[grant]_ready=1, m[grant]_rdata=TIMEOUT_RDATA.
    - timeout_err=1, timeout_master=grant.
    - Next cycle: IDLE, last_grant=grant.
- Non-granted master: ready=0, rdata=0 at all times.
- s_valid always drops for ≥1 cycle (the IDLE cycle) between transactions. A slave that registers ready from valid (ready one cycle after valid) therefore sees exactly one transaction.
- s_ready in IDLE is ignored; it is never forwarded, so a late response after a timeout is discarded.
- s_ready and timeout in the same cycle: s_ready wins, rdata=s_rdata, no timeout_err.
- Requester dropping valid while granted is illegal; behaviour is undefined and no check is required.
- Write transactions complete the same way; rdata content on a write completion is don't-care from the slave, TIMEOUT_RDATA on timeout.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs 0; the in-flight transaction is lost.
- Starvation bound: with both masters continuously requesting, grants alternate strictly 0,1,0,1…

Test Plan:
- Single write: m0 writes addr 31'h4, wdata 32'h41, wstrb 4'b0001; slave readies 1 cycle after s_valid. Expect:
  - s_valid rises 1 cycle after m0_valid.
  - s_addr=31'h4.
  - m0_ready pulses one cycle, coincident with s_ready.
  - s_valid low the next cycle.
- Read pass-through: m1 reads addr 31'h10; slave returns 32'h1234_5678 after 3 cycles. Expect m1_rdata=32'h1234_5678 during the m1_ready pulse; m0_ready stays 0.
- Contention: both valid from reset, 4 transactions each. Expect grant order 0,1,0,1,0,1,0,1 and each master's payload on s_* during its grant only.
- Timeout: TIMEOUT_CYCLES=8, slave never readies, m0 reads. Expect:
  - m0_ready on the 8th BUSY cycle with m0_rdata=32'hDEAD_BEEF.
  - timeout_err one-cycle pulse, timeout_master=0.
  - A pending m1 request is granted next.
- Late ready / tie: with TIMEOUT_CYCLES=8, s_ready on the 8th BUSY cycle returns slave data with no timeout_err. A stray s_ready in IDLE produces no m*_ready.
- Reset mid-BUSY: assert rst_n low 2 cycles into a transaction. Expect s_valid, m*_ready, timeout_err=0 immediately; after release, master 0 wins first contention.
